// File: rtl/if_fetch_unit.sv
// if_fetch_unit: instruction-fetch stage, issues imem requests and buffers up to two {pc, inst} entries for IF/ID.
// Latency: first instruction valid 2 cycles after the first request (1-cycle memory), then one per cycle.
// Backpressure: pause_i holds the head entry; requests stop once buffered + in-flight words reach 2.
module if_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        pause_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_ready_i,
  input  logic        imem_rvalid_i,
  input  logic [31:0] imem_rdata_i,
  output logic        if_valid_o,
  output logic [31:0] if_pc_o,
  output logic [31:0] if_pc4_o,
  output logic [31:0] if_inst_o
);

  // Fetch state
  logic [31:0] r_pc_q;         // next fetch address
  logic [1:0]  r_cnt;          // buffered entries, 0..2
  logic        r_outstanding;  // one request in flight
  logic        r_kill;         // in-flight response belongs to a squashed path
  logic [31:0] r_issued_pc;    // address of the in-flight request
  logic        r_rd_ptr;       // head slot of the 2-entry buffer
  logic [31:0] r_buf_pc   [2];
  logic [31:0] r_buf_inst [2];

  logic        w_pop;
  logic        w_rsp;
  logic        w_push;
  logic        w_req;
  logic        w_accept;
  logic        w_wr_ptr;
  logic [2:0]  w_credit;
  logic [31:0] w_redirect_pc;

  // Head leaves the buffer only when IF/ID actually captures it; a redirect flushes instead.
  assign w_pop    = (r_cnt != 2'd0) && !pause_i && !redirect_i;
  // Responses only count while a request is outstanding; strays after reset are dropped here.
  assign w_rsp    = imem_rvalid_i && r_outstanding;
  assign w_push   = w_rsp && !r_kill && !redirect_i;
  // Slots committed after this edge, excluding any new request: must leave room for one more word.
  assign w_credit = {1'b0, r_cnt} + {2'b00, r_outstanding} - {2'b00, w_pop};
  // Request is held low during reset; a returning response frees the single in-flight slot this cycle.
  assign w_req    = rstn && !redirect_i && (!r_outstanding || imem_rvalid_i) && (w_credit <= 3'd1);
  assign w_accept = w_req && imem_ready_i;
  // Tail slot: head when empty, the other slot when one entry is held.
  assign w_wr_ptr = r_rd_ptr ^ r_cnt[0];
  assign w_redirect_pc = redirect_pc_i & 32'hFFFF_FFFC;

  assign imem_req_o  = w_req;
  assign imem_addr_o = r_pc_q;

  assign if_valid_o = (r_cnt != 2'd0);
  assign if_pc_o    = if_valid_o ? r_buf_pc[r_rd_ptr] : 32'd0;
  assign if_pc4_o   = if_valid_o ? (r_buf_pc[r_rd_ptr] + 32'd4) : 32'd0;
  assign if_inst_o  = if_valid_o ? r_buf_inst[r_rd_ptr] : NOP_INST;

  // Fetch control: pc, occupancy, in-flight tracking and stale-response squashing.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_pc_q        <= RESET_PC;
      r_cnt         <= 2'd0;
      r_outstanding <= 1'b0;
      r_kill        <= 1'b0;
      r_issued_pc   <= 32'd0;
      r_rd_ptr      <= 1'b0;
    end else if (redirect_i) begin
      r_cnt  <= 2'd0;
      r_pc_q <= w_redirect_pc;
      // A response landing this cycle is discarded right here, so only a still-pending one needs killing.
      r_kill <= r_outstanding && !imem_rvalid_i;
      if (w_rsp) begin
        r_outstanding <= 1'b0;
      end
    end else begin
      if (w_accept) begin
        r_pc_q      <= r_pc_q + 32'd4;
        r_issued_pc <= r_pc_q;
      end
      if (w_accept) begin
        r_outstanding <= 1'b1;
      end else if (w_rsp) begin
        r_outstanding <= 1'b0;
      end
      if (w_rsp) begin
        r_kill <= 1'b0;
      end
      r_cnt <= r_cnt + {1'b0, w_push} - {1'b0, w_pop};
      if (w_pop) begin
        r_rd_ptr <= ~r_rd_ptr;
      end
    end
  end

  // Buffer storage: write the returning word with the address it was fetched from.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_buf_pc[0]   <= 32'd0;
      r_buf_pc[1]   <= 32'd0;
      r_buf_inst[0] <= 32'd0;
      r_buf_inst[1] <= 32'd0;
    end else if (w_push) begin
      r_buf_pc[w_wr_ptr]   <= r_issued_pc;
      r_buf_inst[w_wr_ptr] <= imem_rdata_i;
    end
  end

  // The request credit rule must never let a response land in a full buffer.
  a_no_overflow: assert property (@(posedge clk) disable iff (!rstn) !(w_push && (r_cnt == 2'd2)));

endmodule

// File: doc/if_fetch_unit.md
Name: if_fetch_unit

Overview:
- Instruction-fetch stage. Produces the pc / pc+4 / instruction triple consumed by the IF/ID pipeline register.
- Drives the instruction-memory request interface and keeps a 2-entry fetch buffer, so downstream Pause stalls do not lose fetched words.
- Accepts branch/jump redirects from EX, issued in the same cycle as the IF/ID Flush, and discards stale in-flight responses.

Parameters:
- RESET_PC, 32'h0000_0000, first fetch address after reset.
- NOP_INST, 32'h0000_0013, instruction (addi x0,x0,0) presented when no valid instruction is available.

Ports:
- clk  input  1  clock, rising edge.
- rstn  input  1  asynchronous active-low reset.
- pause_i  input  1  downstream stall; same signal as the IF/ID Pause; head entry is not consumed while high.
- redirect_i  input  1  control-flow redirect (taken branch/jump).
- redirect_pc_i  input  32  redirect target.
- imem_req_o  output  1  fetch request.
- imem_addr_o  output  32  fetch address, word aligned.
- imem_ready_i  input  1  memory accepts the request this cycle.
- imem_rvalid_i  input  1  response valid.
- imem_rdata_i  input  32  response instruction word.
- if_valid_o  output  1  head entry is valid.
- if_pc_o  output  32  head pc; 0 when invalid.
- if_pc4_o  output  32  head pc + 4, modulo 2^32; 0 when invalid.
- if_inst_o  output  32  head instruction; NOP_INST when invalid.

Behaviour:
- Reset (async):
  - pc_q = RESET_PC; cnt = 0; outstanding = 0; kill = 0.
  - imem_req_o = 0; if_valid_o = 0; if_inst_o = NOP_INST; if_pc_o and if_pc4_o = 0.
  - Reset mid-transaction drops everything. A response arriving after reset release while outstanding = 0 is ignored.
- State:
  - pc_q: next fetch address.
  - 2-entry FIFO of {pc, inst}, with cnt 0..2.
  - outstanding: 0/1, at most one request in flight.
  - kill: the in-flight response is stale.
- Fetch buffer consumption:
  - pop = (cnt > 0) && !pause_i && !redirect_i.
  - The head is consumed at the clock edge where pop is high.
  - cnt = 0 with pause_i low: IF/ID captures the NOP bubble.
- Memory request:
  - imem_addr_o = pc_q.
  - imem_req_o = !redirect_i && (outstanding == 0 || imem_rvalid_i) && (cnt + outstanding - pop <= 1).
  - Accept occurs when imem_req_o && imem_ready_i. On accept: pc_q += 4 (wraps 0xFFFF_FFFC to 0) and outstanding = 1.
  - Request may deassert before acceptance; the memory must not rely on request stability.
  - Response latency is at least 1 cycle after accept.
- Response handling (imem_rvalid_i, with outstanding = 1):
  - If kill, or redirect_i is high in the same cycle: discard the word and clear kill.
  - Otherwise push {issued pc, imem_rdata_i} to the FIFO tail.
  - outstanding clears unless a new accept happens in the same cycle.
  - A push with a simultaneous pop leaves cnt unchanged.
  - The credit rule guarantees a push never happens with cnt = 2. The implementation asserts this.
  - rvalid with outstanding = 0 is ignored.
- Throughput: with 1-cycle memory and no pause, one instruction per cycle after a 2-cycle startup.
- Redirect (priority over pause and response):
  - At the edge: cnt = 0, and pc_q = {redirect_pc_i[31:2], 2'b00}.
  - If outstanding and no rvalid this cycle: kill = 1.
  - The new request issues in the cycle after redirect, once outstanding is 0 (after a killed response drains).
- Pause:
  - Outputs hold stable.
  - Fetching continues until cnt + outstanding = 2, then imem_req_o = 0.

Test Plan:
- Reset release, RESET_PC = 0, 1-cycle memory returning inst = addr ^ 0xA5A5_0000, pause low:
  - Required: if_valid_o rises 2 cycles after the first request.
  - Required: consecutive edges show pc 0,4,8,12, with if_pc4_o = pc+4 and the matching inst.
- Pause held 4 cycles while streaming:
  - Required: outputs frozen at pc 8; FIFO reaches cnt = 2 (pc 8, 12); imem_req_o = 0.
  - Required: after release, pc 8, 12, 16 delivered with no gap or duplicate.
- Redirect to 0x100 while a request to 0x20 is in flight and memory latency is 3:
  - Required: the 0x20 word is discarded; if_valid_o = 0 with NOP 0x0000_0013.
  - Required: the next request goes to 0x100 after the killed response returns, and if_pc_o = 0x100 follows.
- Redirect with redirect_pc_i = 0x203 in the same cycle as rvalid:
  - Required: the response is dropped, no kill is left set, and the next fetch address is 0x200.
- imem_ready_i low for 3 cycles:
  - Required: imem_addr_o stays constant and pc_q does not advance.
- Start at pc_q = 0xFFFF_FFFC:
  - Required: if_pc4_o = 0 and the next fetch address is 0x0.
- Reset asserted while outstanding with cnt = 2:
  - Required: outputs immediately read if_valid_o = 0 and NOP.
  - Required: a late rvalid after reset release is ignored.
